// File: rtl/cpu_types_pkg.sv
// ID/EX pipeline payload; instantiators size the buffer with $bits(idex_t).
package cpu_types_pkg;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        alu_src;
    logic        reg_dst;
    logic        branch;
    logic        jump;
    logic [3:0]  alu_op;
    logic [31:0] rdat1;
    logic [31:0] rdat2;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [15:0] imm16;
  } idex_t;

endpackage

// File: rtl/pipe_stage_buf_pkg.sv
// Occupancy states for pipe_stage_buf; the encoding doubles as the live-entry count.
package pipe_stage_buf_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/pipe_stage_buf.sv
// Payload-agnostic pipeline register with optional 2-entry skid; 1-cycle in->out latency.
// Backpressure: SKID=1 gives a flop-derived in_ready (low when skid is occupied); SKID=0 passes out_ready through.
module pipe_stage_buf
  import pipe_stage_buf_pkg::*;
#(
  parameter int DW         = 64,
  parameter int SKID       = 1,
  parameter int FLUSH_ZERO = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush,
  output logic [1:0]    count
);

  if (DW < 1) begin : g_bad_dw
    $error("pipe_stage_buf: DW must be >= 1");
  end
  if (SKID != 0 && SKID != 1) begin : g_bad_skid
    $error("pipe_stage_buf: SKID must be 0 or 1");
  end
  if (FLUSH_ZERO != 0 && FLUSH_ZERO != 1) begin : g_bad_fz
    $error("pipe_stage_buf: FLUSH_ZERO must be 0 or 1");
  end

  buf_state_e    state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          push, pop;

  // RST gating holds in_ready low through reset yet lets the first edge after release accept data.
  if (SKID == 1) begin : g_skid_rdy
    assign in_ready = (state_q != ST_FULL) & ~RST;
  end else begin : g_pass_rdy
    assign in_ready = (state_q == ST_EMPTY) | out_ready;
  end

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign count     = state_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      if (FLUSH_ZERO == 1) begin
        main_d = '0;
        skid_d = '0;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && !pop) begin
            skid_d  = in_data;
            state_d = ST_FULL;
          end else if (push && pop) begin
            main_d = in_data;
          end else if (pop) begin
            state_d = ST_EMPTY;
            if (FLUSH_ZERO == 1) main_d = '0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = ST_ONE;
            if (FLUSH_ZERO == 1) skid_d = '0;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed scenarios plus a queue-model random run against a SKID=1 and a SKID=0 instance.
module tb_pipe_stage_buf;
  import cpu_types_pkg::*;

  localparam int DW = $bits(idex_t);

  logic          clk = 1'b0;
  logic          rst;
  logic          a_iv, a_rdy, a_vld, a_ord, a_fl;
  logic [DW-1:0] a_id, a_dat;
  logic [1:0]    a_cnt;
  logic          b_iv, b_rdy, b_vld, b_ord, b_fl;
  logic [DW-1:0] b_id, b_dat;
  logic [1:0]    b_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DW(DW), .SKID(1), .FLUSH_ZERO(1)) u_dut_skid (
    .CLK(clk), .RST(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_rdy),
    .out_valid(a_vld), .out_data(a_dat), .out_ready(a_ord), .flush(a_fl), .count(a_cnt)
  );

  pipe_stage_buf #(.DW(DW), .SKID(0), .FLUSH_ZERO(1)) u_dut_pass (
    .CLK(clk), .RST(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_rdy),
    .out_valid(b_vld), .out_data(b_dat), .out_ready(b_ord), .flush(b_fl), .count(b_cnt)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic vld, input logic [1:0] cnt, input logic [31:0] dat);
    check({tag, ".vld"}, 128'(a_vld), 128'(vld));
    check({tag, ".cnt"}, 128'(a_cnt), 128'(cnt));
    check({tag, ".dat"}, 128'(a_dat), 128'(dat));
  endtask

  task automatic chk_b(input string tag, input logic vld, input logic [1:0] cnt, input logic [31:0] dat);
    check({tag, ".vld"}, 128'(b_vld), 128'(vld));
    check({tag, ".cnt"}, 128'(b_cnt), 128'(cnt));
    check({tag, ".dat"}, 128'(b_dat), 128'(dat));
  endtask

  logic [31:0]   seq [3];
  logic [DW-1:0] qa [$];
  logic [DW-1:0] qb [$];
  logic          ra, rb;

  initial begin
    seq = '{32'h11, 32'h22, 32'h33};
    rst = 1'b1;
    a_iv = 1'b0; a_id = '0; a_ord = 1'b0; a_fl = 1'b0;
    b_iv = 1'b0; b_id = '0; b_ord = 1'b0; b_fl = 1'b0;

    #2;
    chk_a("rst_a", 1'b0, 2'd0, 32'h0);
    chk_b("rst_b", 1'b0, 2'd0, 32'h0);
    check("rst_a.rdy", 128'(a_rdy), 128'h0);
    check("rst_b.rdy", 128'(b_rdy), 128'h1);

    // stream at full rate
    step();
    rst = 1'b0;
    a_ord = 1'b1; a_iv = 1'b1; a_id = DW'(seq[0]);
    #1;
    check("rel.rdy", 128'(a_rdy), 128'h1);
    for (int i = 0; i < 3; i++) begin
      a_id = DW'(seq[i]);
      step();
      chk_a($sformatf("stream%0d", i), 1'b1, 2'd1, seq[i]);
      check($sformatf("stream%0d.rdy", i), 128'(a_rdy), 128'h1);
    end
    a_iv = 1'b0;
    step();
    chk_a("stream_drain", 1'b0, 2'd0, 32'h0);

    // stall fills skid, then drain in order
    a_ord = 1'b0; a_iv = 1'b1; a_id = DW'(32'hA);
    step();
    chk_a("stall1", 1'b1, 2'd1, 32'hA);
    a_id = DW'(32'hB);
    step();
    chk_a("stall2", 1'b1, 2'd2, 32'hA);
    check("stall2.rdy", 128'(a_rdy), 128'h0);
    a_iv = 1'b0;
    step();
    chk_a("stall_hold", 1'b1, 2'd2, 32'hA);
    a_ord = 1'b1;
    step();
    chk_a("drain1", 1'b1, 2'd1, 32'hB);
    check("drain1.rdy", 128'(a_rdy), 128'h1);
    step();
    chk_a("drain0", 1'b0, 2'd0, 32'h0);

    // flush while FULL with a concurrent push
    a_ord = 1'b0; a_iv = 1'b1; a_id = DW'(32'hA);
    step();
    a_id = DW'(32'hB);
    step();
    check("pre_flush.cnt", 128'(a_cnt), 128'h2);
    a_fl = 1'b1; a_id = DW'(32'hC);
    step();
    chk_a("flush_full", 1'b0, 2'd0, 32'h0);
    check("flush_full.rdy", 128'(a_rdy), 128'h1);
    a_fl = 1'b0; a_iv = 1'b0; a_ord = 1'b1;
    step();
    chk_a("flush_after", 1'b0, 2'd0, 32'h0);

    // flush in ONE with in_ready high: the push must not land
    a_ord = 1'b0; a_iv = 1'b1; a_id = DW'(32'hA);
    step();
    a_fl = 1'b1; a_id = DW'(32'hC);
    #1;
    check("flush_one.rdy_seen", 128'(a_rdy), 128'h1);
    step();
    a_fl = 1'b0; a_iv = 1'b0;
    chk_a("flush_one", 1'b0, 2'd0, 32'h0);

    // pass-through mode: replace main on push&pop
    b_ord = 1'b0; b_iv = 1'b1; b_id = DW'(32'h5);
    step();
    chk_b("pass5", 1'b1, 2'd1, 32'h5);
    check("pass5.rdy", 128'(b_rdy), 128'h0);
    b_ord = 1'b1; b_id = DW'(32'h6);
    #1;
    check("pass6.rdy", 128'(b_rdy), 128'h1);
    step();
    chk_b("pass6", 1'b1, 2'd1, 32'h6);
    b_iv = 1'b0;
    step();
    chk_b("pass_drain", 1'b0, 2'd0, 32'h0);

    // async reset mid-cycle while FULL
    a_ord = 1'b0; a_iv = 1'b1; a_id = DW'(32'hA);
    step();
    a_id = DW'(32'hB);
    step();
    a_iv = 1'b0;
    check("pre_rst.cnt", 128'(a_cnt), 128'h2);
    #3 rst = 1'b1;
    #1;
    chk_a("async_rst", 1'b0, 2'd0, 32'h0);
    check("async_rst.rdy", 128'(a_rdy), 128'h0);
    check("async_rst.b_rdy", 128'(b_rdy), 128'h1);
    step();
    rst = 1'b0;
    a_iv = 1'b1; a_id = DW'(32'h7); a_ord = 1'b1;
    step();
    chk_a("post_rst", 1'b1, 2'd1, 32'h7);
    a_iv = 1'b0;
    step();
    chk_a("post_rst_drain", 1'b0, 2'd0, 32'h0);

    // random traffic against reference queues
    for (int cyc = 0; cyc < 10000; cyc++) begin
      check("rnd_a.vld", 128'(a_vld), 128'(qa.size() != 0));
      check("rnd_a.cnt", 128'(a_cnt), 128'(qa.size()));
      if (qa.size() != 0) check("rnd_a.dat", 128'(a_dat), 128'(qa[0]));
      else                check("rnd_a.dat0", 128'(a_dat), 128'h0);
      check("rnd_b.vld", 128'(b_vld), 128'(qb.size() != 0));
      check("rnd_b.cnt", 128'(b_cnt), 128'(qb.size()));
      if (qb.size() != 0) check("rnd_b.dat", 128'(b_dat), 128'(qb[0]));
      else                check("rnd_b.dat0", 128'(b_dat), 128'h0);

      a_iv  = 1'($urandom_range(0, 1));
      a_ord = ($urandom_range(0, 3) != 0);
      a_fl  = ($urandom_range(0, 40) == 0);
      a_id  = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      b_iv  = 1'($urandom_range(0, 1));
      b_ord = ($urandom_range(0, 2) != 0);
      b_fl  = ($urandom_range(0, 40) == 0);
      b_id  = DW'({$urandom(), $urandom(), $urandom(), $urandom()});
      ra = (qa.size() < 2);
      rb = (qb.size() == 0) || b_ord;
      #1;
      check("rnd_a.rdy", 128'(a_rdy), 128'(ra));
      check("rnd_b.rdy", 128'(b_rdy), 128'(rb));

      if (a_fl) qa.delete();
      else begin
        if (qa.size() != 0 && a_ord) void'(qa.pop_front());
        if (a_iv && ra) qa.push_back(a_id);
      end
      if (b_fl) qb.delete();
      else begin
        if (qb.size() != 0 && b_ord) void'(qb.pop_front());
        if (b_iv && rb) qb.push_back(b_id);
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
